// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters with round-robin
// arbitration, registered ALU operands and a single id-tagged response channel.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_zero,
  output logic              rsp_id,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitrating, may accept one request
  // EXEC  | ALU evaluating the registered operands
  // RESP  | result held on the response channel until taken
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_out_q, rsp_out_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_id_q, rsp_id_d;
  logic                last_q, last_d;
  logic                grant;
  logic                idle;
  logic                accept;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle && rst_n && req0_valid && !grant;
  assign req1_ready = idle && rst_n && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_a_d    = grant ? req1_a : req0_a;
          alu_b_d    = grant ? req1_b : req0_b;
          alu_ctrl_d = grant ? req1_ctrl : req0_ctrl;
          rsp_id_d   = grant;
          last_d     = grant;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = alu_out;
        rsp_zero_d  = alu_zero;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to "req1 served last" so req0 wins the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
      last_q      <= last_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = !idle;

endmodule
